// File: rtl/branch_driver.sv
// branch_driver: queues resolved branch outcomes and replays each one to a
// request/result/taken branch predictor, comparing the predictor's answer with
// the real outcome and keeping saturating totals of branches and mispredicts.
module branch_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_taken,
  output logic          in_ready,
  input  logic          run,
  input  logic          stats_clr,
  output logic          request,
  output logic          result,
  output logic          taken,
  input  logic          prediction,
  output logic [CW-1:0] total_count,
  output logic [CW-1:0] miss_count,
  output logic          last_miss,
  output logic          busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RES  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             cur_taken;
  logic             mispredict;

  // Occupancy is a register, so an entry written at this edge only becomes
  // visible to the pop decision at the following edge.
  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign mispredict = (prediction != cur_taken);
  assign busy       = (state != IDLE) || !empty;

  // Next-state logic; a pop happens only when moving into REQ.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (run && !empty) begin
          pop      = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        state_nx = RES;
      end
      RES: begin
        if (run && !empty) begin
          pop      = 1'b1;
          state_nx = REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register and registered predictor-side strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      request <= 1'b0;
      result  <= 1'b0;
      taken   <= 1'b0;
    end else begin
      state   <= state_nx;
      request <= (state_nx == REQ);
      result  <= (state_nx == RES);
      taken   <= (state_nx == RES) && cur_taken;
    end
  end

  // Outcome FIFO: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_taken;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Holds the outcome of the branch currently being replayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_taken <= 1'b0;
    end else if (pop) begin
      cur_taken <= mem[rd_ptr];
    end
  end

  // Statistics, updated at the edge that ends RES; clear wins over an update.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      total_count <= '0;
      miss_count  <= '0;
      last_miss   <= 1'b0;
    end else if (state == RES) begin
      if (total_count != '1) begin
        total_count <= total_count + CW'(1);
      end
      if (mispredict) begin
        if (miss_count != '1) begin
          miss_count <= miss_count + CW'(1);
        end
        last_miss <= 1'b1;
      end else begin
        last_miss <= 1'b0;
      end
    end else begin
      last_miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_driver.sv
// Bench for branch_driver: 2-bit saturating-counter predictor stub, a
// queue-based outcome scoreboard with saturating statistics, directed steps
// and a randomized phase.
module tb_branch_driver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_taken = 1'b0;
  logic          in_ready;
  logic          run = 1'b0;
  logic          stats_clr = 1'b0;
  logic          request;
  logic          result;
  logic          taken;
  logic          prediction = 1'b0;
  logic [CW-1:0] total_count;
  logic [CW-1:0] miss_count;
  logic          last_miss;
  logic          busy;

  int nchecks = 0;
  int nerrors = 0;

  branch_driver #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_taken(in_taken),
    .in_ready(in_ready), .run(run), .stats_clr(stats_clr),
    .request(request), .result(result), .taken(taken),
    .prediction(prediction), .total_count(total_count),
    .miss_count(miss_count), .last_miss(last_miss), .busy(busy)
  );

  always #5 clk = ~clk;

  // Predictor stub: 2-bit saturating counter, no reset, answers on request.
  logic [1:0] pctr = 2'b11;
  logic       pred_fresh = 1'b0;
  always @(posedge clk) begin
    if (pred_fresh) pctr <= 2'b11;
    else if (result) begin
      if (taken && pctr != 2'b11) pctr <= pctr + 2'b01;
      else if (!taken && pctr != 2'b00) pctr <= pctr - 2'b01;
    end
    if (request) prediction <= pctr[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: outcomes in push order, statistics from plain arithmetic.
  bit          mon_en = 1'b0;
  logic        m_q[$];
  int unsigned m_total = 0;
  int unsigned m_miss = 0;
  logic        m_lm = 1'b0;

  always @(negedge clk) begin
    logic et;
    logic mm;
    et = 1'b0;
    mm = 1'b0;
    if (mon_en) begin
      check("total_count", 32'(total_count), m_total);
      check("miss_count", 32'(miss_count), m_miss);
      check("last_miss", 32'(last_miss), 32'(m_lm));
      check("busy", 32'(busy), 32'(m_q.size() != 0));
      check("req_res_excl", 32'(request && result), 0);
      if (!result) check("taken_wo_result", 32'(taken), 0);
      if (rst) begin
        m_total = 0; m_miss = 0; m_lm = 1'b0;
        m_q.delete();
      end else begin
        if (result) begin
          check("res_has_entry", 32'(m_q.size() != 0), 1);
          if (m_q.size() != 0) et = m_q.pop_front();
          check("taken_order", 32'(taken), 32'(et));
          mm = (prediction != et);
        end
        if (stats_clr) begin
          m_total = 0; m_miss = 0; m_lm = 1'b0;
        end else if (result) begin
          if (m_total < SAT) m_total++;
          if (mm && m_miss < SAT) m_miss++;
          m_lm = mm;
        end else begin
          m_lm = 1'b0;
        end
        if (in_valid && in_ready) m_q.push_back(in_taken);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic t);
    in_valid = 1'b1;
    in_taken = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fresh_pred();
    pred_fresh = 1'b1;
    tick();
    pred_fresh = 1'b0;
  endtask

  task automatic drain(input string tag, output int nres);
    int n;
    n = 0;
    nres = 0;
    while (busy && n < 200) begin
      tick();
      if (result) nres++;
      n++;
    end
    check(tag, 32'(busy), 0);
  endtask

  initial begin
    int first, last, nact, np, lm, cnt, n;
    logic preds[4];

    // Reset state
    do_reset();
    check("rst_request", 32'(request), 0);
    check("rst_result", 32'(result), 0);
    check("rst_taken", 32'(taken), 0);
    check("rst_last_miss", 32'(last_miss), 0);
    check("rst_total", 32'(total_count), 0);
    check("rst_miss", 32'(miss_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    mon_en = 1'b1;

    // Single taken branch, cycle-exact timing
    fresh_pred();
    run = 1'b1;
    push1(1'b1);
    check("e0_request", 32'(request), 0);
    tick();
    check("e1_request", 32'(request), 1);
    check("e1_result", 32'(result), 0);
    tick();
    check("e2_request", 32'(request), 0);
    check("e2_result", 32'(result), 1);
    check("e2_taken", 32'(taken), 1);
    tick();
    check("e3_result", 32'(result), 0);
    check("e3_total", 32'(total_count), 1);
    check("e3_miss", 32'(miss_count), 0);
    check("e3_last_miss", 32'(last_miss), 0);

    // Four not-taken back to back: predictions 1,1,0,0, no gaps
    do_reset();
    fresh_pred();
    first = -1; last = -1; nact = 0; np = 0; lm = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid = (cyc < 4);
      in_taken = 1'b0;
      tick();
      if (request || result) begin
        if (first < 0) first = cyc;
        last = cyc;
        nact++;
      end
      if (result && np < 4) begin
        preds[np] = prediction;
        np++;
      end
      if (last_miss) lm++;
    end
    in_valid = 1'b0;
    check("b2b_results", np, 4);
    check("b2b_active", nact, 8);
    check("b2b_span", last - first + 1, 8);
    check("b2b_pred0", 32'(preds[0]), 1);
    check("b2b_pred1", 32'(preds[1]), 1);
    check("b2b_pred2", 32'(preds[2]), 0);
    check("b2b_pred3", 32'(preds[3]), 0);
    check("b2b_total", 32'(total_count), 4);
    check("b2b_miss", 32'(miss_count), 2);
    check("b2b_lm_pulses", lm, 2);

    // Full FIFO with run=0, then exactly DEPTH transactions
    do_reset();
    run = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("fill_in_ready", 32'(in_ready), 32'(i < DEPTH));
      push1(1'($urandom_range(1)));
    end
    check("full_in_ready", 32'(in_ready), 0);
    check("full_request", 32'(request), 0);
    run = 1'b1;
    drain("full_drain_timeout", cnt);
    check("full_txn_count", cnt, DEPTH);

    // run dropped mid-transaction: current pair completes, no new pop
    push1(1'b1);
    push1(1'b0);
    n = 0;
    while (!request && n < 20) begin tick(); n++; end
    check("stall_saw_request", 32'(request), 1);
    run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result) cnt++;
    end
    check("stall_one_txn", cnt, 1);
    check("stall_busy", 32'(busy), 1);
    check("stall_request", 32'(request), 0);
    run = 1'b1;
    drain("stall_drain_timeout", cnt);
    check("stall_resume_txn", cnt, 1);

    // stats_clr at the RES-ending edge discards that update
    push1(1'b1);
    n = 0;
    while (!result && n < 20) begin tick(); n++; end
    check("clr_saw_result", 32'(result), 1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("clr_total", 32'(total_count), 0);
    check("clr_miss", 32'(miss_count), 0);
    check("clr_last_miss", 32'(last_miss), 0);
    push1(1'b0);
    drain("clr_drain_timeout", cnt);
    check("clr_next_total", 32'(total_count), 1);

    // Nine mispredicts with CW=3: both counters saturate at 7
    do_reset();
    fresh_pred();
    for (int i = 0; i < 9; i++) begin
      push1(~pctr[1]);
      drain("sat_drain_timeout", cnt);
    end
    check("sat_miss", 32'(miss_count), SAT);
    check("sat_total", 32'(total_count), SAT);
    repeat (5) tick();
    check("sat_miss_held", 32'(miss_count), SAT);
    check("sat_total_held", 32'(total_count), SAT);

    // Reset during REQ aborts the transaction
    push1(1'b1);
    n = 0;
    while (!request && n < 20) begin tick(); n++; end
    check("abort_saw_request", 32'(request), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_request", 32'(request), 0);
    check("abort_result", 32'(result), 0);
    check("abort_total", 32'(total_count), 0);
    check("abort_miss", 32'(miss_count), 0);
    check("abort_busy", 32'(busy), 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (result) cnt++;
    end
    check("abort_no_result", cnt, 0);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      run       = ($urandom_range(3) != 0);
      in_valid  = 1'($urandom_range(1));
      in_taken  = 1'($urandom_range(1));
      stats_clr = ($urandom_range(31) == 0);
      rst       = ($urandom_range(127) == 0);
      tick();
    end
    in_valid = 1'b0;
    stats_clr = 1'b0;
    rst = 1'b0;
    run = 1'b1;
    drain("rand_drain_timeout", cnt);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
